// File: rtl/npu_pkg.sv
// Shared NPU datapath constants and helpers.
// Exposes the popcount width/range used between the popcount stage and the
// bit-plane accumulator, plus the default accumulator result width.
package npu_pkg;

  // Popcount of 11 inputs fits in 4 bits; legal values are 0..11.
  localparam int               CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'd11;

  // 11 * (2^BITS - 1) < 2^(BITS+4), so BITS+5 signed bits hold every result.
  function automatic int out_w_default(input int bits);
    return bits + 5;
  endfunction

endpackage

// File: rtl/bitplane_accumulator_if.sv
// Plane-count input stream and weighted-sum output stream of the accumulator.
// Ports: cnt_in/in_valid/in_ready (per-plane popcount), acc_out/out_valid/
// out_ready (finished sum), plane_idx and range_err (status).
interface bitplane_accumulator_if
  import npu_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int OUT_W = out_w_default(BITS)
) ();

  localparam int PW = $clog2(BITS);

  logic [CNT_W-1:0]        cnt_in;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [OUT_W-1:0] acc_out;
  logic                    out_valid;
  logic                    out_ready;
  logic [PW-1:0]           plane_idx;
  logic                    range_err;

  // master: popcount producer / result consumer side.
  modport master (
    output cnt_in, in_valid, out_ready,
    input  in_ready, acc_out, out_valid, plane_idx, range_err
  );

  // slave: the accumulator itself.
  modport slave (
    input  cnt_in, in_valid, out_ready,
    output in_ready, acc_out, out_valid, plane_idx, range_err
  );

endinterface

// File: rtl/bitplane_accumulator.sv
// Accumulates BITS popcount planes (LSB first, plane k weighted 2^k, MSB plane
// optionally -2^(BITS-1)) into a signed sum held in a valid/ready output reg.
// Ports: clk, reset (async, active-high), bus (slave side of the plane/result
// streams). Result is registered 1 cycle after the final plane is accepted;
// only the final plane stalls, and only while an undrained result is held.
module bitplane_accumulator
  import npu_pkg::*;
#(
  parameter int BITS       = 8,
  parameter int SIGNED_MSB = 1,
  parameter int OUT_W      = out_w_default(BITS)
) (
  input logic                   clk,
  input logic                   reset,
  bitplane_accumulator_if.slave bus
);

  localparam int            PW         = $clog2(BITS);
  localparam logic [PW-1:0] LAST_PLANE = PW'(BITS - 1);

  logic [PW-1:0]           plane;
  logic signed [OUT_W-1:0] acc;
  logic signed [OUT_W-1:0] acc_out_q;
  logic                    out_valid_q;
  logic                    range_err_q;

  logic                    last;
  logic                    accept;
  logic signed [OUT_W-1:0] mag;
  logic signed [OUT_W-1:0] term;
  logic signed [OUT_W-1:0] sum;

  assign last   = (plane == LAST_PLANE);
  // The final plane completes a result, so it may only enter when the output
  // register is free or is being drained in this same cycle.
  assign bus.in_ready = !(last && out_valid_q && !bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    mag  = OUT_W'(bus.cnt_in) << plane;
    term = mag;
    if ((SIGNED_MSB != 0) && last) begin
      term = -mag;
    end
    sum = acc + term;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      plane       <= '0;
      acc         <= '0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      if (accept && (bus.cnt_in > CNT_MAX)) begin
        range_err_q <= 1'b1;
      end
      if (accept && last) begin
        // Loading a new result wins over a simultaneous drain.
        acc_out_q   <= sum;
        out_valid_q <= 1'b1;
        acc         <= '0;
        plane       <= '0;
      end else begin
        if (accept) begin
          acc   <= sum;
          plane <= plane + PW'(1);
        end
        if (out_valid_q && bus.out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.acc_out   = acc_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.plane_idx = plane;
  assign bus.range_err = range_err_q;

endmodule

// File: tb/tb_bitplane_accumulator.sv
module tb_bitplane_accumulator;
  import npu_pkg::*;

  localparam int BITS     = 8;
  localparam int OUT_W    = out_w_default(BITS);
  localparam int WAIT_MAX = 40;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bitplane_accumulator_if #(.BITS(BITS), .OUT_W(OUT_W)) ifu ();
  bitplane_accumulator_if #(.BITS(BITS), .OUT_W(OUT_W)) ifs ();

  bitplane_accumulator #(.BITS(BITS), .SIGNED_MSB(0), .OUT_W(OUT_W)) dut_u (
    .clk(clk), .reset(reset), .bus(ifu.slave));
  bitplane_accumulator #(.BITS(BITS), .SIGNED_MSB(1), .OUT_W(OUT_W)) dut_s (
    .clk(clk), .reset(reset), .bus(ifs.slave));

  // Shared driver; sel routes the plane stream to the signed (1) or unsigned (0) DUT.
  logic             sel  = 1'b0;
  logic [CNT_W-1:0] cnt  = '0;
  logic             vld  = 1'b0;
  logic             ordy = 1'b0;

  assign ifu.cnt_in    = cnt;
  assign ifu.in_valid  = vld & ~sel;
  assign ifu.out_ready = ordy;
  assign ifs.cnt_in    = cnt;
  assign ifs.in_valid  = vld & sel;
  assign ifs.out_ready = ordy;

  logic rdy;
  assign rdy = sel ? ifs.in_ready : ifu.in_ready;

  int     total = 0;
  int     bad   = 0;
  int     stalls;
  bit     mon_on  = 1'b0;
  bit     rand_on = 1'b0;
  int     c[BITS];
  longint qu[$];
  longint qs[$];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: weighted sum of the plane counts straight from the definition.
  function automatic longint model(input bit sgn);
    longint s = 0;
    for (int k = 0; k < BITS; k++) begin
      longint w = longint'(1) << k;
      if (sgn && k == BITS - 1) w = -w;
      s += longint'(c[k]) * w;
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_on) ordy = ($urandom_range(0, 3) != 0);
  endtask

  // Presents one plane and returns #1 after the edge that accepted it; vld stays high.
  task automatic send_plane(input int v);
    cnt = CNT_W'(v);
    vld = 1'b1;
    for (int w = 0; w < WAIT_MAX; w++) begin
      @(negedge clk);
      if (rdy) begin
        tick();
        return;
      end
      stalls++;
      tick();
    end
    chk("in_ready_timeout", 0, 1);
  endtask

  task automatic send_all();
    for (int k = 0; k < BITS; k++) send_plane(c[k]);
  endtask

  task automatic fill(input int v);
    for (int k = 0; k < BITS; k++) c[k] = v;
  endtask

  // Output scoreboard and no-retraction check for the randomized phase.
  bit                      hold_u = 1'b0, hold_s = 1'b0;
  logic signed [OUT_W-1:0] held_u, held_s;

  always @(negedge clk) begin
    if (mon_on) begin
      if (hold_u) begin
        chk("u_hold_valid", ifu.out_valid, 1);
        chk("u_hold_data", ifu.acc_out, held_u);
      end
      hold_u = ifu.out_valid && !ifu.out_ready;
      held_u = ifu.acc_out;
      if (ifu.out_valid && ifu.out_ready) begin
        if (qu.size() == 0) chk("u_spurious_result", 1, 0);
        else chk("u_rand_result", ifu.acc_out, qu.pop_front());
      end
      if (hold_s) begin
        chk("s_hold_valid", ifs.out_valid, 1);
        chk("s_hold_data", ifs.acc_out, held_s);
      end
      hold_s = ifs.out_valid && !ifs.out_ready;
      held_s = ifs.acc_out;
      if (ifs.out_valid && ifs.out_ready) begin
        if (qs.size() == 0) chk("s_spurious_result", 1, 0);
        else chk("s_rand_result", ifs.acc_out, qs.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ifu.out_valid, 0);
    chk("rst_acc_out", ifu.acc_out, 0);
    chk("rst_plane_idx", ifu.plane_idx, 0);
    chk("rst_range_err", ifu.range_err, 0);
    chk("rst_s_out_valid", ifs.out_valid, 0);
    reset = 1'b0;
    ordy  = 1'b1;
    tick();
    chk("rst_in_ready", ifu.in_ready, 1);

    // Unsigned, 11 on every plane: 11*255
    sel = 1'b0;
    fill(11);
    for (int k = 0; k < BITS - 1; k++) send_plane(c[k]);
    chk("u11_not_early", ifu.out_valid, 0);
    send_plane(c[BITS-1]);
    vld = 1'b0;
    chk("u11_valid", ifu.out_valid, 1);
    chk("u11_acc", ifu.acc_out, 2805);
    chk("u11_plane_wrap", ifu.plane_idx, 0);
    tick();
    chk("u11_drained", ifu.out_valid, 0);
    chk("u11_acc_holds", ifu.acc_out, 2805);

    // Signed: MSB plane only, then all-but-MSB
    sel = 1'b1;
    fill(0);
    c[BITS-1] = 11;
    send_all();
    chk("s_msb_valid", ifs.out_valid, 1);
    chk("s_msb_acc", ifs.acc_out, -1408);
    fill(11);
    c[BITS-1] = 0;
    send_all();
    vld = 1'b0;
    chk("s_low_acc", ifs.acc_out, 1397);
    chk("s_range_err", ifs.range_err, 0);

    // Backpressure on the final plane
    sel = 1'b0;
    repeat (2) tick();
    ordy = 1'b0;
    fill(2);
    send_all();
    chk("bp_first_acc", ifu.acc_out, 510);
    fill(3);
    stalls = 0;
    for (int k = 0; k < BITS - 1; k++) send_plane(c[k]);
    chk("bp_no_early_stall", stalls, 0);
    chk("bp_plane7", ifu.plane_idx, 7);
    chk("bp_acc_held", ifu.acc_out, 510);
    cnt = CNT_W'(3);
    vld = 1'b1;
    @(negedge clk);
    chk("bp_stall_a", ifu.in_ready, 0);
    tick();
    @(negedge clk);
    chk("bp_stall_b", ifu.in_ready, 0);
    chk("bp_valid_held", ifu.out_valid, 1);
    chk("bp_acc_stable", ifu.acc_out, 510);
    tick();
    ordy = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", ifu.in_ready, 1);
    tick();
    vld = 1'b0;
    chk("bp_second_acc", ifu.acc_out, 765);
    chk("bp_second_valid", ifu.out_valid, 1);
    tick();
    chk("bp_second_drained", ifu.out_valid, 0);

    // Full throughput: 3 back-to-back results
    stalls = 0;
    for (int r = 1; r <= 3; r++) begin
      fill(r);
      for (int k = 0; k < BITS; k++) begin
        send_plane(c[k]);
        if (k == 0 && r > 1) chk("tp_pulse_low", ifu.out_valid, 0);
      end
      chk("tp_valid", ifu.out_valid, 1);
      chk("tp_acc", ifu.acc_out, 255 * r);
    end
    vld = 1'b0;
    chk("tp_no_stall", stalls, 0);

    // Out-of-range count is summed as given and flags sticky range_err
    tick();
    fill(0);
    c[0] = 13;
    send_all();
    vld = 1'b0;
    chk("oor_acc", ifu.acc_out, 13);
    chk("oor_err", ifu.range_err, 1);
    fill(0);
    send_all();
    vld = 1'b0;
    chk("oor_sticky", ifu.range_err, 1);
    chk("oor_next_acc", ifu.acc_out, 0);

    // Reset mid-accumulation while a result is held
    ordy = 1'b0;
    fill(5);
    for (int k = 0; k < 4; k++) send_plane(c[k]);
    vld = 1'b0;
    chk("mid_pre_plane", ifu.plane_idx, 4);
    reset = 1'b1;
    #1;
    chk("mid_out_valid", ifu.out_valid, 0);
    chk("mid_plane_idx", ifu.plane_idx, 0);
    chk("mid_range_err", ifu.range_err, 0);
    tick();
    reset = 1'b0;
    ordy  = 1'b1;
    tick();
    fill(1);
    send_all();
    vld = 1'b0;
    chk("mid_clean_acc", ifu.acc_out, 255);

    // Randomized streams to both DUTs with random gaps and backpressure
    repeat (3) tick();
    mon_on  = 1'b1;
    rand_on = 1'b1;
    for (int r = 0; r < 40; r++) begin
      sel = 1'($urandom_range(0, 1));
      for (int k = 0; k < BITS; k++) c[k] = $urandom_range(0, 11);
      for (int k = 0; k < BITS; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          vld = 1'b0;
          tick();
        end
        send_plane(c[k]);
      end
      if (sel) qs.push_back(model(1'b1));
      else     qu.push_back(model(1'b0));
    end
    vld     = 1'b0;
    rand_on = 1'b0;
    ordy    = 1'b1;
    for (int w = 0; w < 20 && (qu.size() != 0 || qs.size() != 0); w++) tick();
    tick();
    chk("rand_u_all_out", qu.size(), 0);
    chk("rand_s_all_out", qs.size(), 0);
    mon_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
